// File: rtl/tennis_score.sv
// tennis_score
//   Scores one tennis set from the per-rally point pulses of ball_movement.
//   Tracks point codes (0/15/30/40/AD) through deuce and advantage. Counts
//   games and alternates the server. After each game it freezes the score
//   for a fixed number of cycles. It stops in a terminal state once a
//   player reaches the games target.
//
// Parameters
//   GAMES_TO_WIN  games needed to take the set (1..7)
//   PAUSE_CYCLES  cycles the score is frozen after a game (1..65535)
//
// Ports
//   clk        system clock, rising edge
//   reset_clk  synchronous, active-high reset
//   point_p1   rally won by player 1 (one point per high cycle)
//   point_p2   rally won by player 2 (one point per high cycle)
//   p1_pts     player 1 point code: 0=0, 1=15, 2=30, 3=40, 4=AD
//   p2_pts     player 2 point code, same encoding
//   p1_games   player 1 games in the set
//   p2_games   player 2 games in the set
//   server     current server: 0=P1, 1=P2
//   game_won   one-cycle pulse when a game is decided
//   winner     00=none, 01=P1, 10=P2; valid with game_won and while set_over
//   set_over   high once the set is finished, until reset
module tennis_score #(
    parameter int unsigned GAMES_TO_WIN = 6,
    parameter int unsigned PAUSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_clk,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic [2:0] p1_pts,
    output logic [2:0] p2_pts,
    output logic [2:0] p1_games,
    output logic [2:0] p2_games,
    output logic       server,
    output logic       game_won,
    output logic [1:0] winner,
    output logic       set_over
);

    typedef enum logic [2:0] {
        PLAY,
        DEUCE,
        ADV_P1,
        ADV_P2,
        PAUSE,
        DONE
    } state_t;

    localparam logic [2:0]  GAMES_MAX  = GAMES_TO_WIN[2:0];
    localparam logic [15:0] PAUSE_LAST = 16'(PAUSE_CYCLES - 1);

    localparam logic [2:0] CODE_40 = 3'd3;
    localparam logic [2:0] CODE_AD = 3'd4;

    state_t      state, state_nxt;
    logic        pt1_q, pt2_q;
    logic [15:0] pause_cnt, pause_cnt_nxt;

    logic [2:0]  p1_pts_nxt, p2_pts_nxt;
    logic [2:0]  p1_games_nxt, p2_games_nxt;
    logic        server_nxt, game_won_nxt, set_over_nxt;
    logic [1:0]  winner_nxt;

    logic        one_p1, one_p2;
    logic        win_p1, win_p2;

    // Pulses are registered once before scoring. Capture is blocked while
    // the score is frozen or the set is over, so a pulse arriving on the
    // last pause cycle cannot leak into the next game.
    always_ff @(posedge clk) begin
        if (reset_clk) begin
            pt1_q <= 1'b0;
            pt2_q <= 1'b0;
        end else begin
            pt1_q <= point_p1 && (state != PAUSE) && (state != DONE);
            pt2_q <= point_p2 && (state != PAUSE) && (state != DONE);
        end
    end

    // Simultaneous pulses cancel: neither player scores that cycle.
    assign one_p1 = pt1_q && !pt2_q;
    assign one_p2 = pt2_q && !pt1_q;

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            state     <= PLAY;
            pause_cnt <= '0;
            p1_pts    <= '0;
            p2_pts    <= '0;
            p1_games  <= '0;
            p2_games  <= '0;
            server    <= 1'b0;
            game_won  <= 1'b0;
            winner    <= '0;
            set_over  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pause_cnt <= pause_cnt_nxt;
            p1_pts    <= p1_pts_nxt;
            p2_pts    <= p2_pts_nxt;
            p1_games  <= p1_games_nxt;
            p2_games  <= p2_games_nxt;
            server    <= server_nxt;
            game_won  <= game_won_nxt;
            winner    <= winner_nxt;
            set_over  <= set_over_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pause_cnt_nxt = pause_cnt;
        p1_pts_nxt    = p1_pts;
        p2_pts_nxt    = p2_pts;
        p1_games_nxt  = p1_games;
        p2_games_nxt  = p2_games;
        server_nxt    = server;
        game_won_nxt  = 1'b0;
        winner_nxt    = (state == DONE) ? winner : 2'b00;
        set_over_nxt  = set_over;
        win_p1        = 1'b0;
        win_p2        = 1'b0;

        case (state)
            PLAY: begin
                // Both codes at 40 is never held in PLAY: reaching it
                // moves straight to DEUCE.
                if (one_p1) begin
                    if (p1_pts < CODE_40) begin
                        p1_pts_nxt = p1_pts + 3'd1;
                        if (p1_pts == 3'd2 && p2_pts == CODE_40)
                            state_nxt = DEUCE;
                    end else begin
                        win_p1 = 1'b1;
                    end
                end else if (one_p2) begin
                    if (p2_pts < CODE_40) begin
                        p2_pts_nxt = p2_pts + 3'd1;
                        if (p2_pts == 3'd2 && p1_pts == CODE_40)
                            state_nxt = DEUCE;
                    end else begin
                        win_p2 = 1'b1;
                    end
                end
            end

            DEUCE: begin
                if (one_p1) begin
                    p1_pts_nxt = CODE_AD;
                    p2_pts_nxt = CODE_40;
                    state_nxt  = ADV_P1;
                end else if (one_p2) begin
                    p1_pts_nxt = CODE_40;
                    p2_pts_nxt = CODE_AD;
                    state_nxt  = ADV_P2;
                end
            end

            ADV_P1: begin
                if (one_p1) begin
                    win_p1 = 1'b1;
                end else if (one_p2) begin
                    p1_pts_nxt = CODE_40;
                    p2_pts_nxt = CODE_40;
                    state_nxt  = DEUCE;
                end
            end

            ADV_P2: begin
                if (one_p2) begin
                    win_p2 = 1'b1;
                end else if (one_p1) begin
                    p1_pts_nxt = CODE_40;
                    p2_pts_nxt = CODE_40;
                    state_nxt  = DEUCE;
                end
            end

            PAUSE: begin
                if (pause_cnt == PAUSE_LAST) begin
                    pause_cnt_nxt = '0;
                    p1_pts_nxt    = '0;
                    p2_pts_nxt    = '0;
                    state_nxt     = PLAY;
                end else begin
                    pause_cnt_nxt = pause_cnt + 16'd1;
                end
            end

            DONE: begin
                set_over_nxt = 1'b1;
            end

            default: begin
                state_nxt = PLAY;
            end
        endcase

        // Game win: point codes keep their pre-win values through PAUSE.
        if (win_p1 || win_p2) begin
            game_won_nxt  = 1'b1;
            server_nxt    = ~server;
            pause_cnt_nxt = '0;
            state_nxt     = PAUSE;
            if (win_p1) begin
                winner_nxt = 2'b01;
                if (p1_games < GAMES_MAX)
                    p1_games_nxt = p1_games + 3'd1;
                if ({1'b0, p1_games} + 4'd1 >= {1'b0, GAMES_MAX}) begin
                    state_nxt    = DONE;
                    set_over_nxt = 1'b1;
                end
            end else begin
                winner_nxt = 2'b10;
                if (p2_games < GAMES_MAX)
                    p2_games_nxt = p2_games + 3'd1;
                if ({1'b0, p2_games} + 4'd1 >= {1'b0, GAMES_MAX}) begin
                    state_nxt    = DONE;
                    set_over_nxt = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tennis_score.sv
module tb_tennis_score;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u_dut: default parameters; u_set: two-game set
    logic       rst_a, pa1, pa2;
    logic [2:0] a_p1_pts, a_p2_pts, a_p1_games, a_p2_games;
    logic       a_server, a_game_won, a_set_over;
    logic [1:0] a_winner;

    logic       rst_b, pb1, pb2;
    logic [2:0] b_p1_pts, b_p2_pts, b_p1_games, b_p2_games;
    logic       b_server, b_game_won, b_set_over;
    logic [1:0] b_winner;

    tennis_score u_dut (
        .clk(clk), .reset_clk(rst_a), .point_p1(pa1), .point_p2(pa2),
        .p1_pts(a_p1_pts), .p2_pts(a_p2_pts),
        .p1_games(a_p1_games), .p2_games(a_p2_games),
        .server(a_server), .game_won(a_game_won),
        .winner(a_winner), .set_over(a_set_over)
    );

    tennis_score #(.GAMES_TO_WIN(2), .PAUSE_CYCLES(4)) u_set (
        .clk(clk), .reset_clk(rst_b), .point_p1(pb1), .point_p2(pb2),
        .p1_pts(b_p1_pts), .p2_pts(b_p2_pts),
        .p1_games(b_p1_games), .p2_games(b_p2_games),
        .server(b_server), .game_won(b_game_won),
        .winner(b_winner), .set_over(b_set_over)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle of pulses, then wait one
    // more cycle so the registered result is visible at return.
    task automatic point(input int which, input logic a, input logic b);
        if (which == 1) begin pa1 = a; pa2 = b; end
        else            begin pb1 = a; pb2 = b; end
        @(negedge clk);
        if (which == 1) begin pa1 = 1'b0; pa2 = 1'b0; end
        else            begin pb1 = 1'b0; pb2 = 1'b0; end
        @(negedge clk);
    endtask

    task automatic check_a(input string tag, input int p1, input int p2,
                           input int g1, input int g2, input int srv,
                           input int gw, input int win, input int so);
        check({tag, ".p1_pts"},   a_p1_pts,   p1);
        check({tag, ".p2_pts"},   a_p2_pts,   p2);
        check({tag, ".p1_games"}, a_p1_games, g1);
        check({tag, ".p2_games"}, a_p2_games, g2);
        check({tag, ".server"},   a_server,   srv);
        check({tag, ".game_won"}, a_game_won, gw);
        check({tag, ".winner"},   a_winner,   win);
        check({tag, ".set_over"}, a_set_over, so);
    endtask

    task automatic check_b(input string tag, input int p1, input int p2,
                           input int g1, input int g2, input int srv,
                           input int gw, input int win, input int so);
        check({tag, ".p1_pts"},   b_p1_pts,   p1);
        check({tag, ".p2_pts"},   b_p2_pts,   p2);
        check({tag, ".p1_games"}, b_p1_games, g1);
        check({tag, ".p2_games"}, b_p2_games, g2);
        check({tag, ".server"},   b_server,   srv);
        check({tag, ".game_won"}, b_game_won, gw);
        check({tag, ".winner"},   b_winner,   win);
        check({tag, ".set_over"}, b_set_over, so);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        pa1 = 1'b0; pa2 = 1'b0; pb1 = 1'b0; pb2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        check_a("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check_b("reset_b", 0, 0, 0, 0, 0, 0, 0, 0);

        // Love game for P1
        point(1, 1, 0); check("love1", a_p1_pts, 1);
        point(1, 1, 0); check("love2", a_p1_pts, 2);
        point(1, 1, 0); check("love3", a_p1_pts, 3);
        point(1, 1, 0);
        check_a("love_win", 3, 0, 1, 0, 1, 1, 1, 0);

        // Pause masking: P2 held high across all four pause cycles
        pa2 = 1'b1;
        @(negedge clk);
        check("pause.game_won", a_game_won, 0);
        check("pause.winner", a_winner, 0);
        check("pause.pts_frozen", a_p1_pts, 3);
        repeat (3) @(negedge clk);
        pa2 = 1'b0;
        check_a("pause_end", 0, 0, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        check("pause_leak.p2_pts", a_p2_pts, 0);
        check("pause_leak.p2_games", a_p2_games, 0);

        // Simultaneous pulses at 15-30
        point(1, 1, 0); check("sim.15_0", a_p1_pts, 1);
        point(1, 0, 1); check("sim.15_15", a_p2_pts, 1);
        point(1, 0, 1); check("sim.15_30", a_p2_pts, 2);
        point(1, 1, 1);
        check("sim.both.p1", a_p1_pts, 1);
        check("sim.both.p2", a_p2_pts, 2);
        point(1, 0, 1);
        check("sim.after.p1", a_p1_pts, 1);
        check("sim.after.p2", a_p2_pts, 3);

        // Into ADV_P1 with one game banked, then reset with a pulse pending
        point(1, 1, 0); check("adv.30_40", a_p1_pts, 2);
        point(1, 1, 0);
        check("adv.deuce.p1", a_p1_pts, 3);
        check("adv.deuce.p2", a_p2_pts, 3);
        point(1, 1, 0);
        check_a("adv_p1", 4, 3, 1, 0, 1, 0, 0, 0);
        rst_a = 1'b1; pa1 = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; pa1 = 1'b0;
        check_a("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("mid_reset.no_leak", a_p1_pts, 0);
        point(1, 1, 0);
        check_a("after_reset", 1, 0, 0, 0, 0, 0, 0, 0);

        // Deuce cycle
        point(1, 1, 0);
        point(1, 1, 0);
        point(1, 0, 1);
        point(1, 0, 1);
        check("deuce.40_30", a_p2_pts, 2);
        point(1, 0, 1);
        check("deuce.p1", a_p1_pts, 3);
        check("deuce.p2", a_p2_pts, 3);
        point(1, 0, 1);
        check("adv2.p1", a_p1_pts, 3);
        check("adv2.p2", a_p2_pts, 4);
        point(1, 1, 0);
        check("back_deuce.p1", a_p1_pts, 3);
        check("back_deuce.p2", a_p2_pts, 3);
        point(1, 1, 0);
        check("adv1.p1", a_p1_pts, 4);
        point(1, 1, 0);
        check_a("deuce_win", 4, 3, 1, 0, 1, 1, 1, 0);

        // Set end on the two-game instance: P2 wins two love games
        repeat (4) point(2, 0, 1);
        check_b("set.g1", 0, 3, 0, 1, 1, 1, 2, 0);
        repeat (5) @(negedge clk);
        check("set.g1_cleared", b_p2_pts, 0);
        repeat (3) point(2, 0, 1);
        check("set.g2_40", b_p2_pts, 3);
        point(2, 0, 1);
        check_b("set.g2", 0, 3, 0, 2, 0, 1, 2, 1);
        @(negedge clk);
        check_b("set.hold", 0, 3, 0, 2, 0, 0, 2, 1);
        point(2, 1, 0);
        point(2, 0, 1);
        point(2, 1, 1);
        repeat (6) point(2, 1, 0);
        check_b("set.frozen", 0, 3, 0, 2, 0, 0, 2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
